axi4_lite_master_bridge: RTL and testbench
==========================================

Name: axi4_lite_master_bridge

Overview:
- Initiator end of the AXI4-Lite link: converts a single-outstanding simple request/response bus into AXI4-Lite write and read transactions.
- Sits between local control logic (sequencers, DMA descriptor loaders) and AXI4-Lite register slaves.
- One transaction in flight at a time.
- AW and W are issued together; each channel drops VALID independently on its own handshake.

Parameters:
AW, 32, address width
DW, 32, data width
SW, DW/8, write strobe width

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
req_valid  input  1  request present
req_ready  output  1  bridge can accept request
req_we  input  1  1=write, 0=read
req_addr  input  AW  byte address
req_wdata  input  DW  write data
req_wstrb  input  SW  write byte enables
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  DW  read data (valid with rsp_valid on reads)
rsp_resp  output  2  AXI response code (BRESP or RRESP)
axi_awaddr/awprot/awvalid  output  AW/3/1  write address channel
axi_awready  input  1  write address accepted
axi_wdata/wstrb/wvalid  output  DW/SW/1  write data channel
axi_wready  input  1  write data accepted
axi_bresp/bvalid  input  2/1  write response
axi_bready  output  1  write response accept
axi_araddr/arprot/arvalid  output  AW/3/1  read address channel
axi_arready  input  1  read address accepted
axi_rdata/rresp/rvalid  input  DW/2/1  read data channel
axi_rready  output  1  read data accept

Behaviour:
- Reset values (asynchronous, immediate): all VALID and READY outputs 0; req_ready 0 while rst is high, 1 from the first clock after release; rsp_valid 0; rsp_rdata 0; rsp_resp 0; address, data and strobe registers 0; state IDLE.
- AXI PROT outputs are constant 3'b000.
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA.
- IDLE:
  - req_ready=1.
  - On req_valid: latch addr, wdata, wstrb, we.
  - Write -> WR_ADDR_DATA with awvalid=wvalid=1 from the next cycle.
  - Read -> RD_ADDR with arvalid=1 from the next cycle.
- req_ready=0 in every non-IDLE state; requests are neither accepted nor queued there.
- WR_ADDR_DATA:
  - awvalid drops the cycle after awvalid&awready; wvalid drops the cycle after wvalid&wready. The two may complete in the same cycle or in either order.
  - Once both handshakes are done -> WR_RESP with bready=1.
  - Address and data stay stable while their VALID is high.
- WR_RESP: on bvalid&bready, register bresp, pulse rsp_valid for 1 cycle, bready=0, -> IDLE.
- RD_ADDR: arvalid held until arready; then arvalid=0, rready=1, -> RD_DATA.
- RD_DATA: on rvalid&rready, register rdata and rresp, pulse rsp_valid, rready=0, -> IDLE.
- Latency: the response pulse is registered, so rsp_valid rises the cycle after the B or R handshake.
- rsp_rdata holds its last read value until the next read completes; writes leave it unchanged.
- Back-to-back: a new request can be accepted in the same cycle rsp_valid is high (state is already IDLE). Minimum period is 4 cycles per transaction with zero-wait slaves.
- Early responses:
  - bvalid arriving before both AW and W handshakes is not accepted; bready stays 0 until both are done.
  - rvalid is likewise ignored until RD_DATA.
- Non-OKAY responses (SLVERR 2'b10, DECERR 2'b11) are passed through on rsp_resp; no retry.
- VALID signals never depend combinationally on READY inputs. All AXI outputs are driven from registers.
- Reset mid-transaction: all VALID/READY outputs drop asynchronously and no rsp_valid is produced. The in-flight transaction is lost; upstream reissues it.

Decomposition:
- Package axi4_lite_pkg:
  - resp enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - state enum for the five states.
  - PROT default constant.
- No sub-module: a single FSM plus channel-done flags (aw_done, w_done) is the natural size.

Test Plan:
- Write, zero-wait:
  - Stimulus: req addr 0x4000_0010, wdata 0xDEAD_BEEF, wstrb 0xF; slave awready=wready=1, bvalid the cycle after bready, OKAY.
  - Required: awvalid/wvalid high exactly 1 cycle with matching addr/data; rsp_valid one cycle with rsp_resp=0; total 4 cycles from request accept to rsp_valid.
- Skewed write handshakes:
  - Stimulus: wready at cycle 1, awready at cycle 4.
  - Required: wvalid drops after cycle 1; awvalid held with stable 0x4000_0010 through cycle 4; bready rises only after both handshakes.
- Read with wait states:
  - Stimulus: addr 0x0000_0100, arready after 3 cycles, rvalid 2 cycles later with rdata 0x1234_5678, rresp SLVERR.
  - Required: rsp_rdata=0x1234_5678, rsp_resp=2'b10; req_ready=0 throughout the transaction.
- Early bvalid:
  - Stimulus: slave raises bvalid before awready.
  - Required: bready stays 0 until both handshakes complete; exactly one rsp_valid pulse.
- Back-to-back:
  - Stimulus: write then read presented continuously.
  - Required: read accepted in the rsp_valid cycle of the write; rsp_rdata unchanged by the write.
- Reset mid-read:
  - Stimulus: assert rst while arvalid=1.
  - Required: arvalid drops to 0 without waiting for a clock edge; no rsp_valid; req_ready=1 on the first clock after release.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite master bridge: response codes, FSM states
// and the fixed protection attribute driven on AW/AR.
package axi4_lite_pkg;

  // AXI response codes carried on BRESP/RRESP and passed through to rsp_resp.
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  // One transaction in flight; the state names the channel being waited on.
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_DATA      = 3'd4
  } state_t;

  // Unprivileged, secure, data access for every transaction.
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi4_lite_master_bridge_if.sv
// AXI4-Lite bus bundle between the bridge (master) and a register slave.
//
// Handshake rule on every channel: a transfer happens on a rising clock edge
// where VALID and READY are both high. The source holds VALID and its payload
// stable until that edge; READY may rise or fall freely while VALID is low.
interface axi4_lite_master_bridge_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = DW / 8
);

  // Write address channel
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          awvalid;
  logic          awready;

  // Write data channel
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          wvalid;
  logic          wready;

  // Write response channel
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;

  // Read address channel
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready;

  // Read data channel
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi4_lite_master_bridge.sv
// Single-outstanding request/response bus to AXI4-Lite master bridge.
// A request is accepted only in IDLE; writes issue AW and W together, each
// dropping VALID on its own handshake, then wait for B. Reads issue AR then
// wait for R. Completion is a registered one-cycle rsp_valid pulse.
// Every AXI output comes straight from a flop, so no VALID depends
// combinationally on a READY input.
module axi4_lite_master_bridge
  import axi4_lite_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = DW / 8
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [SW-1:0] req_wstrb,

  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic [1:0]    rsp_resp,

  output state_t        dbg_state,

  axi4_lite_master_bridge_if.master axi
);

  state_t        state_q, state_d;
  logic          run_q;

  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;

  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          bready_q, bready_d;
  logic          arvalid_q, arvalid_d;
  logic          rready_q, rready_d;

  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  resp_t         resp_q, resp_d;

  // Inside WR_ADDR_DATA a channel is finished once its VALID has dropped.
  logic          aw_done;
  logic          w_done;
  logic          aw_fin;
  logic          w_fin;

  assign aw_done = ~awvalid_q;
  assign w_done  = ~wvalid_q;
  // A channel is finished by the coming edge if already done or handshaking now.
  assign aw_fin  = aw_done | axi.awready;
  assign w_fin   = w_done  | axi.wready;

  // run_q keeps req_ready low during reset and lets it rise one clock after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Next-state and next-register values; every target defaults to hold.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    resp_d      = resp_q;

    case (state_q)
      IDLE: begin
        if (req_valid && run_q) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          if (req_we) begin
            state_d   = WR_ADDR_DATA;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end

      WR_ADDR_DATA: begin
        if (awvalid_q && axi.awready) begin
          awvalid_d = 1'b0;
        end
        if (wvalid_q && axi.wready) begin
          wvalid_d = 1'b0;
        end
        // bready is only raised once both AW and W have transferred, so an
        // early bvalid from the slave is simply left waiting.
        if (aw_fin && w_fin) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end

      WR_RESP: begin
        if (axi.bvalid && bready_q) begin
          resp_d      = resp_t'(axi.bresp);
          rsp_valid_d = 1'b1;
          bready_d    = 1'b0;
          state_d     = IDLE;
        end
      end

      RD_ADDR: begin
        if (arvalid_q && axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (axi.rvalid && rready_q) begin
          rdata_d     = axi.rdata;
          resp_d      = resp_t'(axi.rresp);
          rsp_valid_d = 1'b1;
          rready_d    = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and all registered outputs; reset clears every VALID/READY at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      resp_q      <= OKAY;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
    end
  end

  assign req_ready   = run_q & (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = resp_q;
  assign dbg_state   = state_q;

  assign axi.awaddr  = addr_q;
  assign axi.awprot  = PROT_DEFAULT;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;
  assign axi.araddr  = addr_q;
  assign axi.arprot  = PROT_DEFAULT;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master_bridge.sv
// Bench for axi4_lite_master_bridge: directed scenarios plus randomized
// transactions against a transaction-level model of the bridge.
module tb_axi4_lite_master_bridge;
  import axi4_lite_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  state_t      dbg_state;

  axi4_lite_master_bridge_if #(.AW(32), .DW(32), .SW(4)) axi ();

  axi4_lite_master_bridge #(.AW(32), .DW(32), .SW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .dbg_state (dbg_state),
    .axi       (axi)
  );

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];   // {resp, rdata} of each completion owed by the bridge
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model state ----------------
  bit          busy, run;
  bit          cur_we, aw_done, w_done, ar_done;
  logic [31:0] cur_addr, cur_wdata;
  logic [3:0]  cur_wstrb;
  logic [31:0] exp_rdata;

  // values present during the clock edge being evaluated
  bit          p_rst, p_req_valid, p_req_we, p_rsp_valid;
  logic [31:0] p_req_addr, p_req_wdata, p_awaddr, p_rdata;
  logic [3:0]  p_req_wstrb;
  bit          p_awvalid, p_awready, p_wvalid, p_wready, p_bvalid, p_bready;
  bit          p_arvalid, p_arready, p_rvalid, p_rready;
  logic [1:0]  p_bresp, p_rresp;

  // slave behaviour knobs
  int          aw_wait, w_wait, ar_wait, b_wait, r_wait;
  bit          early_b, early_r;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic [31:0] cfg_rdata;
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;

  // observations for the directed literal checks
  int          cyc, acc_cyc, last_lat, rsp_cnt, aw_hi, w_hi;
  bit          acc_now, acc_in_rsp;
  logic [31:0] last_rdata, last_awaddr;
  logic [1:0]  last_resp;

  // One clock: evaluate handshakes of the edge, compare, then drive the slave.
  task automatic step();
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs, acc, ev;
    logic [33:0] e;
    p_rst = rst; p_req_valid = req_valid; p_req_we = req_we;
    p_req_addr = req_addr; p_req_wdata = req_wdata; p_req_wstrb = req_wstrb;
    p_rsp_valid = rsp_valid;
    p_awvalid = axi.awvalid; p_awready = axi.awready; p_awaddr = axi.awaddr;
    p_wvalid = axi.wvalid; p_wready = axi.wready;
    p_bvalid = axi.bvalid; p_bready = axi.bready; p_bresp = axi.bresp;
    p_arvalid = axi.arvalid; p_arready = axi.arready;
    p_rvalid = axi.rvalid; p_rready = axi.rready; p_rdata = axi.rdata; p_rresp = axi.rresp;
    @(posedge clk);
    #1;
    cyc++;
    acc_now = 0; b_hs = 0; r_hs = 0;
    if (p_rst) begin
      busy = 0; run = 0; exp_rdata = '0; exp_q.delete();
    end else begin
      aw_hs = p_awvalid && p_awready;
      w_hs  = p_wvalid && p_wready;
      b_hs  = p_bvalid && p_bready;
      ar_hs = p_arvalid && p_arready;
      r_hs  = p_rvalid && p_rready;
      acc   = p_req_valid && run && !busy;
      if (p_awvalid) begin aw_cnt++; aw_hi++; end
      if (p_wvalid) begin w_cnt++; w_hi++; end
      if (p_arvalid) ar_cnt++;
      if (p_bready) b_cnt++;
      if (p_rready) r_cnt++;
      if (aw_hs) begin aw_done = 1; last_awaddr = p_awaddr; end
      if (w_hs) w_done = 1;
      if (ar_hs) ar_done = 1;
      if (b_hs) begin exp_q.push_back({p_bresp, exp_rdata}); busy = 0; end
      if (r_hs) begin exp_rdata = p_rdata; exp_q.push_back({p_rresp, p_rdata}); busy = 0; end
      if (acc) begin
        busy = 1; cur_we = p_req_we; cur_addr = p_req_addr;
        cur_wdata = p_req_wdata; cur_wstrb = p_req_wstrb;
        aw_done = 0; w_done = 0; ar_done = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_hi = 0; w_hi = 0;
        acc_now = 1; acc_in_rsp = p_rsp_valid;
        acc_cyc = cyc - 1;   // index of the cycle in which req_valid&req_ready were high
      end
      run = 1;
    end

    // compare
    chk("req_ready", req_ready, run && !busy);
    chk("awvalid", axi.awvalid, busy && cur_we && !aw_done);
    chk("wvalid", axi.wvalid, busy && cur_we && !w_done);
    chk("bready", axi.bready, busy && cur_we && aw_done && w_done);
    chk("arvalid", axi.arvalid, busy && !cur_we && !ar_done);
    chk("rready", axi.rready, busy && !cur_we && ar_done);
    if (busy && cur_we && !aw_done) chk("awaddr", axi.awaddr, cur_addr);
    if (busy && cur_we && !w_done) begin
      chk("wdata", axi.wdata, cur_wdata);
      chk("wstrb", axi.wstrb, cur_wstrb);
    end
    if (busy && !cur_we && !ar_done) chk("araddr", axi.araddr, cur_addr);
    chk("prot", {axi.awprot, axi.arprot}, 32'd0);
    ev = (exp_q.size() != 0);
    chk("rsp_valid", rsp_valid, ev);
    if (ev) begin
      e = exp_q.pop_front();
      chk("rsp_resp", rsp_resp, e[33:32]);
      chk("rsp_rdata", rsp_rdata, e[31:0]);
      rsp_cnt++;
      last_lat = cyc - acc_cyc;
      last_rdata = rsp_rdata;
      last_resp = rsp_resp;
    end else begin
      chk("rsp_rdata_hold", rsp_rdata, exp_rdata);
    end

    // slave responder
    axi.awready = axi.awvalid ? (aw_cnt >= aw_wait) : 1'($urandom_range(0, 1));
    axi.wready  = axi.wvalid  ? (w_cnt >= w_wait)   : 1'($urandom_range(0, 1));
    axi.arready = axi.arvalid ? (ar_cnt >= ar_wait) : 1'($urandom_range(0, 1));
    if (b_hs) begin
      axi.bvalid = 1'b0;
    end else if (!axi.bvalid && busy && cur_we && (early_b || (axi.bready && b_cnt >= b_wait))) begin
      axi.bvalid = 1'b1;
      axi.bresp  = cfg_bresp;
    end
    if (r_hs) begin
      axi.rvalid = 1'b0;
    end else if (!axi.rvalid && busy && !cur_we && (early_r || (axi.rready && r_cnt >= r_wait))) begin
      axi.rvalid = 1'b1;
      axi.rdata  = cfg_rdata;
      axi.rresp  = cfg_rresp;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb);
    int n;
    req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    req_valid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!acc_now && n < 300);
    if (!acc_now) chk("accept_timeout", 32'd0, 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (busy && n < 300);
    if (busy) chk("complete_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_slave(input int aw, input int w, input int ar, input int b, input int r,
                           input bit eb, input bit er);
    aw_wait = aw; w_wait = w; ar_wait = ar; b_wait = b; r_wait = r;
    early_b = eb; early_r = er;
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    busy = 0; run = 0; exp_rdata = '0; exp_q.delete();
    axi.bvalid = 1'b0; axi.rvalid = 1'b0;
    chk("rst_arvalid_async", axi.arvalid, 32'd0);
    chk("rst_awvalid_async", axi.awvalid, 32'd0);
    chk("rst_rready_async", axi.rready, 32'd0);
    chk("rst_req_ready", req_ready, 32'd0);
    chk("rst_rsp_valid", rsp_valid, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_resp", rsp_resp, 32'd0);
    chk("rst_state", dbg_state, IDLE);
    step();
    step();
    rst = 1'b0;
    step();
    chk("ready_after_release", req_ready, 32'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    miscompares++;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int w_acc;
    rst = 1'b0;
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    axi.awready = 0; axi.wready = 0; axi.arready = 0;
    axi.bvalid = 0; axi.bresp = '0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = '0;
    busy = 0; run = 0; exp_rdata = '0; cyc = 0; acc_cyc = 0; rsp_cnt = 0;
    cur_we = 0; cur_addr = '0; cur_wdata = '0; cur_wstrb = '0;
    aw_done = 0; w_done = 0; ar_done = 0;
    set_slave(0, 0, 0, 1, 1, 0, 0);
    cfg_bresp = OKAY; cfg_rresp = OKAY; cfg_rdata = '0;

    // power-on reset, checked before any clock edge
    #1 rst = 1'b1;
    #1;
    async_reset();

    // zero-wait write
    set_slave(0, 0, 0, 1, 1, 0, 0);
    cfg_bresp = OKAY; rsp_cnt = 0;
    send(1, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF);
    wait_idle();
    chk("t1_latency", last_lat, 32'd4);
    chk("t1_resp", last_resp, 32'd0);
    chk("t1_aw_cycles", aw_hi, 32'd1);
    chk("t1_w_cycles", w_hi, 32'd1);
    chk("t1_pulses", rsp_cnt, 32'd1);

    // skewed write: W accepted first cycle, AW on the fourth
    set_slave(3, 0, 0, 1, 1, 0, 0);
    send(1, 32'h4000_0010, 32'h0BAD_F00D, 4'h5);
    wait_idle();
    chk("t2_aw_cycles", aw_hi, 32'd4);
    chk("t2_w_cycles", w_hi, 32'd1);
    chk("t2_awaddr", last_awaddr, 32'h4000_0010);

    // read with wait states and SLVERR
    set_slave(0, 0, 3, 1, 2, 0, 0);
    cfg_rdata = 32'h1234_5678; cfg_rresp = SLVERR;
    send(0, 32'h0000_0100, 32'h0, 4'h0);
    wait_idle();
    chk("t3_rdata", last_rdata, 32'h1234_5678);
    chk("t3_resp", last_resp, 32'd2);
    chk("t3_latency", last_lat, 32'd8);

    // early bvalid before AW/W complete
    set_slave(2, 1, 0, 0, 0, 1, 0);
    cfg_bresp = DECERR; rsp_cnt = 0;
    send(1, 32'h4000_0040, 32'h5555_AAAA, 4'h3);
    wait_idle();
    chk("t4_pulses", rsp_cnt, 32'd1);
    chk("t4_resp", last_resp, 32'd3);
    chk("t4_latency", last_lat, 32'd5);

    // back-to-back write then read
    set_slave(0, 0, 0, 1, 1, 0, 0);
    cfg_bresp = OKAY; cfg_rdata = 32'hA5A5_0001; cfg_rresp = OKAY;
    send(1, 32'h4000_0020, 32'hCAFE_F00D, 4'hF);
    w_acc = acc_cyc;
    send(0, 32'h0000_0200, 32'h0, 4'h0);
    chk("t5_accept_in_rsp", acc_in_rsp, 32'd1);
    chk("t5_period", acc_cyc - w_acc, 32'd4);
    chk("t5_wr_keeps_rdata", last_rdata, 32'h1234_5678);
    wait_idle();
    chk("t5_rdata", last_rdata, 32'hA5A5_0001);

    // reset while arvalid is high
    set_slave(0, 0, 20, 1, 1, 0, 0);
    rsp_cnt = 0;
    send(0, 32'h0000_0300, 32'h0, 4'h0);
    step();
    chk("t6_arvalid_before", axi.arvalid, 32'd1);
    async_reset();
    step();
    step();
    chk("t6_no_rsp", rsp_cnt, 32'd0);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 2), $urandom_range(0, 2),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
      cfg_bresp = 2'($urandom_range(0, 3));
      cfg_rresp = 2'($urandom_range(0, 3));
      cfg_rdata = $urandom;
      send(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) != 0) wait_idle();
    end
    wait_idle();
    step();
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
